// File: rtl/kv_pkg.sv
// Shared key-table definitions: request/response flag encodings, entry layout, index hash.
package kv_pkg;

    localparam int KV_KEY_SIZE = 96;
    localparam int KV_TBL_AW   = 10;
    localparam int KV_ENTRY_W  = KV_KEY_SIZE + 1;
    localparam int KV_FOLDS    = (KV_KEY_SIZE + KV_TBL_AW - 1) / KV_TBL_AW;

    localparam logic [3:0] FLAG_GET    = 4'b0001;
    localparam logic [3:0] FLAG_SET    = 4'b0010;
    localparam logic [3:0] FLAG_DEL    = 4'b0100;

    localparam logic [3:0] RSP_MISS    = 4'b0000;
    localparam logic [3:0] RSP_HIT     = 4'b0001;
    localparam logic [3:0] RSP_WRITTEN = 4'b0010;
    localparam logic [3:0] RSP_REMOVED = 4'b0100;
    localparam logic [3:0] RSP_EVICT   = 4'b1000;
    localparam logic [3:0] RSP_ERR     = 4'b1000;

    typedef struct packed {
        logic                   vld;
        logic [KV_KEY_SIZE-1:0] key;
    } entry_t;

    // XOR-fold of the key in TBL_AW-bit chunks from bit 0; the top chunk is zero-extended.
    function automatic logic [KV_TBL_AW-1:0] kv_hash(input logic [KV_KEY_SIZE-1:0] key);
        logic [KV_FOLDS*KV_TBL_AW-1:0] padded;
        logic [KV_TBL_AW-1:0]          h;
        padded = (KV_FOLDS*KV_TBL_AW)'(key);
        h      = '0;
        for (int c = 0; c < KV_FOLDS; c++) begin
            h = h ^ padded[c*KV_TBL_AW +: KV_TBL_AW];
        end
        return h;
    endfunction

endpackage

// File: rtl/kv_table_ram.sv
// Key table storage: simple dual-port synchronous RAM, read-first, contents unreset.
// Latency: read data registered one cycle after the address edge.
// Backpressure: none; one read and one write accepted every cycle.
module kv_table_ram #(
    parameter int AW = 10,
    parameter int DW = 97
) (
    input  logic          clk156,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/kv_responder.sv
// Key-value responder: GET/SET/DEL against a direct-mapped table cleared by a post-reset sweep.
// Latency: response registered exactly 2 edges after the request is sampled.
// Backpressure: none; one request per cycle accepted indefinitely, one response each.
module kv_responder
    import kv_pkg::*;
#(
    parameter int KEY_SIZE = KV_KEY_SIZE,
    parameter int TBL_AW   = KV_TBL_AW,
    parameter int LATENCY  = 2
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic [KEY_SIZE-1:0] in_key,
    input  logic [3:0]          in_flag,
    input  logic                in_valid,
    output logic                out_valid,
    output logic [3:0]          out_flag,
    output logic                init_done,
    output logic [7:0]          debug
);

    logic [TBL_AW-1:0]   sweep_idx;
    logic                init_done_q;
    logic [LATENCY-1:0]  vld_pipe;
    logic                s1_vld;
    logic                s2_vld;

    logic [TBL_AW-1:0]   rd_idx;
    entry_t              ram_ent;
    logic                ram_we;
    logic [TBL_AW-1:0]   ram_waddr;
    entry_t              ram_wdat;

    logic [KEY_SIZE-1:0] s1_key;
    logic [3:0]          s1_flag;
    logic [TBL_AW-1:0]   s1_idx;
    logic                s1_live;

    logic [KEY_SIZE-1:0] s2_key;
    logic [3:0]          s2_flag;
    logic [TBL_AW-1:0]   s2_idx;
    logic                s2_live;
    entry_t              s2_ent;

    logic                s2_match;
    logic                s2_we;
    entry_t              s2_new;
    logic [3:0]          s2_rsp;
    logic                s2_hit;

    logic                wq_en;
    logic [TBL_AW-1:0]   wq_idx;
    entry_t              wq_ent;

    logic [6:0]          hit_cnt;

    assign s1_vld = vld_pipe[0];
    assign s2_vld = vld_pipe[LATENCY-1];
    assign rd_idx = kv_hash(in_key);

    kv_table_ram #(
        .AW (TBL_AW),
        .DW (KV_ENTRY_W)
    ) u_ram (
        .clk156  (clk156),
        .rd_addr (rd_idx),
        .rd_dat  (ram_ent),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_dat  (ram_wdat)
    );

    // Sweep owns the write port until init_done; gated by reset so nothing is written while held.
    always_comb begin
        if (!init_done_q) begin
            ram_we    = eth_rst_n;
            ram_waddr = sweep_idx;
            ram_wdat  = '0;
        end else begin
            ram_we    = s2_vld && s2_we;
            ram_waddr = s2_idx;
            ram_wdat  = s2_new;
        end
    end

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            sweep_idx   <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            sweep_idx <= sweep_idx + 1'b1;
            if (&sweep_idx) begin
                init_done_q <= 1'b1;
            end
        end
    end

    assign s2_match = s2_ent.vld && (s2_ent.key == s2_key);

    always_comb begin
        s2_we  = 1'b0;
        s2_new = s2_ent;
        s2_rsp = RSP_ERR;
        s2_hit = 1'b0;
        if (s2_live) begin
            case (s2_flag)
                FLAG_GET: begin
                    s2_hit = s2_match;
                    s2_rsp = s2_match ? RSP_HIT : RSP_MISS;
                end
                FLAG_SET: begin
                    s2_we      = 1'b1;
                    s2_new.vld = 1'b1;
                    s2_new.key = s2_key;
                    s2_rsp     = (s2_ent.vld && !s2_match) ? (RSP_EVICT | RSP_WRITTEN) : RSP_WRITTEN;
                end
                FLAG_DEL: begin
                    if (s2_match) begin
                        s2_we      = 1'b1;
                        s2_new.vld = 1'b0;
                        s2_rsp     = RSP_REMOVED;
                    end else begin
                        s2_rsp = RSP_MISS;
                    end
                end
                default: s2_rsp = RSP_ERR;
            endcase
        end
    end

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            vld_pipe  <= '0;
            s1_key    <= '0;
            s1_flag   <= '0;
            s1_idx    <= '0;
            s1_live   <= 1'b0;
            s2_key    <= '0;
            s2_flag   <= '0;
            s2_idx    <= '0;
            s2_live   <= 1'b0;
            s2_ent    <= '0;
            wq_en     <= 1'b0;
            wq_idx    <= '0;
            wq_ent    <= '0;
            out_valid <= 1'b0;
            out_flag  <= '0;
            hit_cnt   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-2:0], in_valid};
            s1_key   <= in_key;
            s1_flag  <= in_flag;
            s1_idx   <= rd_idx;
            s1_live  <= init_done_q;

            s2_key  <= s1_key;
            s2_flag <= s1_flag;
            s2_idx  <= s1_idx;
            s2_live <= s1_live;
            // RAM read saw neither the write committing now nor the one from the previous edge.
            if (s1_vld && s2_vld && s2_we && (s2_idx == s1_idx)) begin
                s2_ent <= s2_new;
            end else if (wq_en && (wq_idx == s1_idx)) begin
                s2_ent <= wq_ent;
            end else begin
                s2_ent <= ram_ent;
            end

            wq_en  <= ram_we;
            wq_idx <= ram_waddr;
            wq_ent <= ram_wdat;

            out_valid <= s2_vld;
            if (s2_vld) begin
                out_flag <= s2_rsp;
                if (s2_hit) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end
        end
    end

    assign init_done = init_done_q;
    assign debug     = {init_done_q, hit_cnt};

endmodule

// File: tb/tb_kv_responder.sv
// Bench for kv_responder: directed vectors plus a reference-model stream, scoreboard-checked.
module tb_kv_responder;
    import kv_pkg::*;

    localparam int N = 1 << KV_TBL_AW;

    logic        clk156 = 1'b0;
    logic        eth_rst_n;
    logic [95:0] in_key;
    logic [3:0]  in_flag;
    logic        in_valid;
    logic        out_valid;
    logic [3:0]  out_flag;
    logic        init_done;
    logic [7:0]  debug;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];

    logic        mdl_vld [0:N-1];
    logic [95:0] mdl_key [0:N-1];
    logic [6:0]  mdl_hits;

    logic [95:0] keys [0:7];

    kv_responder dut (
        .clk156    (clk156),
        .eth_rst_n (eth_rst_n),
        .in_key    (in_key),
        .in_flag   (in_flag),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .out_flag  (out_flag),
        .init_done (init_done),
        .debug     (debug)
    );

    always #3 clk156 = ~clk156;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Serialized reference: applies one request to the model table, returns the expected flag.
    function automatic logic [3:0] model(input logic [95:0] k, input logic [3:0] f, input bit live);
        logic [KV_TBL_AW-1:0] idx;
        bit hit;
        if (!live) return 4'b1000;
        idx = kv_hash(k);
        hit = mdl_vld[idx] && (mdl_key[idx] == k);
        case (f)
            4'b0001: begin
                if (hit) begin
                    mdl_hits = mdl_hits + 7'd1;
                    return 4'b0001;
                end
                return 4'b0000;
            end
            4'b0010: begin
                bit ev;
                ev = mdl_vld[idx] && !hit;
                mdl_vld[idx] = 1'b1;
                mdl_key[idx] = k;
                return ev ? 4'b1010 : 4'b0010;
            end
            4'b0100: begin
                if (hit) begin
                    mdl_vld[idx] = 1'b0;
                    return 4'b0100;
                end
                return 4'b0000;
            end
            default: return 4'b1000;
        endcase
    endfunction

    task automatic issue(input logic [95:0] k, input logic [3:0] f, input logic [3:0] req, input bit use_model);
        int at;
        bit live;
        logic [3:0] m;
        at   = cyc + 1;
        live = (at - rel_cyc) >= N + 1;
        m    = model(k, f, live);
        exp_q.push_back(use_model ? m : req);
        exp_cyc_q.push_back(at + 2);
        in_key   = k;
        in_flag  = f;
        in_valid = 1'b1;
        @(negedge clk156);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk156);
    endtask

    task automatic pulse_reset(input int hold);
        in_valid  = 1'b0;
        eth_rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        for (int i = 0; i < N; i++) mdl_vld[i] = 1'b0;
        mdl_hits = '0;
        @(negedge clk156);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_flag", 32'(out_flag), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_debug", 32'(debug), 32'd0);
        repeat (hold) @(negedge clk156);
        eth_rst_n = 1'b1;
        rel_cyc   = cyc;
    endtask

    // Monitor: every out_valid pops one expectation and checks flag and arrival cycle.
    initial begin
        logic [3:0] ef;
        int ec;
        forever begin
            @(posedge clk156);
            cyc++;
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected cyc=%0d actual flag=%b required=no response", cyc, out_flag);
                end else begin
                    ef = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (out_flag !== ef || cyc != ec) begin
                        failures++;
                        $display("FAIL rsp actual flag=%b cyc=%0d required flag=%b cyc=%0d", out_flag, cyc, ef, ec);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        eth_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        in_flag   = '0;
        mdl_hits  = '0;
        keys[0] = 96'h1;          keys[1] = 96'h400;
        keys[2] = 96'h100000;     keys[3] = 96'h40000000;
        keys[4] = 96'h2;          keys[5] = 96'h800;
        keys[6] = 96'h200000;     keys[7] = 96'h80000000;
        @(negedge clk156);
        pulse_reset(2);

        idle(2);
        issue(96'h1, FLAG_GET, 4'b1000, 1'b0);
        while (cyc < rel_cyc + N - 1) @(negedge clk156);
        chk("init_done_early", 32'(init_done), 32'd0);
        @(negedge clk156);
        chk("init_done_rise", 32'(init_done), 32'd1);
        idle(1);

        issue(96'h1, FLAG_GET, 4'b0000, 1'b0);
        issue(96'h1, FLAG_SET, 4'b0010, 1'b0);
        issue(96'h1, FLAG_GET, 4'b0001, 1'b0);
        issue(96'h1, FLAG_DEL, 4'b0100, 1'b0);
        issue(96'h1, FLAG_GET, 4'b0000, 1'b0);
        idle(4);
        chk("debug_after_seq", 32'(debug), 32'h81);

        issue(96'h1,   FLAG_SET, 4'b0010, 1'b0);
        issue(96'h400, FLAG_SET, 4'b1010, 1'b0);
        issue(96'h1,   FLAG_GET, 4'b0000, 1'b0);
        issue(96'h400, FLAG_GET, 4'b0001, 1'b0);
        idle(4);
        chk("debug_after_evict", 32'(debug), 32'h82);

        issue(96'h400, 4'b0011, 4'b1000, 1'b0);
        issue(96'h400, 4'b0000, 4'b1000, 1'b0);
        issue(96'h400, 4'b1000, 4'b1000, 1'b0);
        issue(96'h400, FLAG_GET, 4'b0001, 1'b0);
        issue(96'h2,   FLAG_SET, 4'b0010, 1'b0);
        idle(1);
        issue(96'h2,   FLAG_GET, 4'b0001, 1'b0);
        idle(4);
        chk("debug_after_illegal", 32'(debug), 32'h84);

        for (int i = 0; i < 10000; i++) begin
            int r;
            logic [3:0] f;
            if (i == 5000) pulse_reset(3);
            r = $urandom_range(0, 9);
            f = (r < 3) ? FLAG_GET : (r < 6) ? FLAG_SET : (r < 9) ? FLAG_DEL : 4'b0011;
            issue(keys[$urandom_range(0, 7)], f, 4'b0000, 1'b1);
        end
        idle(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("debug_final", 32'(debug), 32'({1'b1, mdl_hits}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kv_responder.md
Name: kv_responder

Overview:
Key-value responder at the far end of the Ethernet encapsulation's lookup interface, in the clk156 domain.
- Accepts one request per cycle (key + op flag, valid-only, no backpressure).
- Performs GET/SET/DEL against an on-chip direct-mapped key table.
- Returns a fixed-latency response flag to the packet encapsulator.
- Used as the mitigation blacklist store behind eth_encap.

Parameters:
KEY_SIZE, 96, request key width in bits
TBL_AW, 10, table index width; table holds 2^TBL_AW entries
LATENCY, 2, in_valid-to-out_valid latency in cycles; fixed, not tunable in v1

Ports:
clk156  in  1  Ethernet core clock, 156.25 MHz; all logic on rising edge
eth_rst_n  in  1  asynchronous active-low reset
in_key  in  KEY_SIZE  request key, sampled when in_valid=1
in_flag  in  4  op one-hot: 0001 GET, 0010 SET, 0100 DEL; any other value is illegal
in_valid  in  1  request strobe, one request per cycle, no ready signal
out_valid  out  1  response strobe, one cycle per accepted request
out_flag  out  4  response: bit0 hit, bit1 written, bit2 removed, bit3 evict/error
init_done  out  1  table clear sweep complete
debug  out  8  {init_done, GET-hit counter[6:0]}

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0 while eth_rst_n=0: out_valid, out_flag, init_done, debug. Pipeline valid bits are cleared.
- Clear sweep:
  - Starts on the first edge after reset release.
  - Writes entry valid=0 to index 0..2^TBL_AW-1, one per cycle.
  - init_done rises on the edge after index 2^TBL_AW-1 is written and stays high until the next reset.
- Requests during the sweep: table unchanged; response 1000 at normal latency.
- Index hash:
  - XOR-fold in_key into TBL_AW-bit chunks starting at bit 0.
  - The final partial chunk is zero-extended.
  - Defined in the package; used by both the RTL and the bench model.
- Entry format: {valid, key[KEY_SIZE-1:0]}.
- Pipeline:
  - Request sampled at edge k; out_valid/out_flag are high for exactly the cycle after edge k+LATENCY.
  - Throughput is 1 request/cycle, sustained indefinitely.
  - A table write commits at the same edge the response registers.
- GET: match = valid && key==in_key.
  - Match: flag 0001, hit counter +1 (wraps mod 128).
  - No match: flag 0000.
- SET:
  - Slot empty or same key: write, flag 0010.
  - Slot holds a different key: overwrite, flag 1010.
- DEL:
  - Match: write valid=0, flag 0100.
  - No match: no write, flag 0000.
- Illegal flag (zero or multi-bit): no write, flag 1000.
- Hazard rule: back-to-back requests to the same index, at any spacing including consecutive cycles, must return results identical to strictly serialized execution. This requires bypass of in-flight writes over stale RAM read data; bypass depth covers every write not yet visible at the RAM read port.
- out_flag holds its last value when out_valid=0. Consumers qualify with out_valid.
- Reset asserted mid-operation: in-flight requests are dropped with no response; no partial write may occur after assertion. After release the sweep reruns.

Decomposition:
- kv_pkg: flag constants (FLAG_GET/SET/DEL, RSP_HIT/WRITTEN/REMOVED/EVICT, RSP_ERR=1000), entry width, hash function.
- Sub-module kv_table_ram: simple dual-port synchronous RAM, 2^TBL_AW x (KEY_SIZE+1), one read port and one write port, read-first. No reset on contents; cleared by the sweep.
- The top holds the sweep counter, hash stage, compare/bypass stage, response register and debug counter.

Test Plan:
- Reset, then hold in_valid=0 for 2^TBL_AW+2 cycles -> init_done rises after exactly 2^TBL_AW cycles post-release; out_valid stays 0.
- GET key 96'h1 during sweep -> out_flag 1000 two cycles later; after init, GET 96'h1 -> 0000.
- SET 96'h1, GET 96'h1, DEL 96'h1, GET 96'h1 on consecutive cycles -> 0010, 0001, 0100, 0000, each two cycles after its request; debug[6:0]=1.
- SET 96'h1 then SET 96'h400 (same index 1), back-to-back -> 0010, 1010; GET 96'h1 -> 0000; GET 96'h400 -> 0001.
- in_flag 0011 and 0000 -> 1000 each; a following GET of a previously set key still hits, confirming no table change.
- Random stream of 10k requests at 100% load over 8 keys sharing 2 indices; reset pulsed mid-stream -> every response matches the serialized reference model, no out_valid for in-flight requests, sweep reruns after release.
